// File: rtl/mf_clken_nco.sv
// Multi-channel fractional clock-enable generator built from phase accumulators.
// Every channel adds its increment to its accumulator each running cycle. The
// carry out of that addition is the enable pulse, and the accumulator MSB is the
// level output. All channels are loaded together, so channels with the same
// increment and phase stay bit-identical.
module mf_clken_nco #(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic [NUM_CH*ACC_W-1:0] cfg_inc,
  input  logic [NUM_CH*ACC_W-1:0] cfg_phase,
  input  logic                    cfg_update,
  output logic                    cfg_ack,
  input  logic                    run,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       clk_out,
  output logic                    locked
);

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  typedef logic [NUM_CH-1:0][ACC_W-1:0] acc_arr_t;

  state_t               state_q, state_d;
  acc_arr_t             acc_q, acc_d;
  acc_arr_t             inc_q, inc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0]    ce_d, clk_d;
  logic                 ack_d, locked_d;
  logic                 step;
  logic                 terminal;
  logic [ACC_W:0]       sum;

  // Next state, settle counter, accumulator update and next output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    inc_d    = inc_q;
    ce_d     = '0;
    clk_d    = clk_out;
    ack_d    = 1'b0;
    locked_d = 1'b0;
    step     = 1'b0;
    sum      = '0;
    terminal = (cnt_q == CNT_W'(LOCK_CYCLES - 1));

    case (state_q)
      ST_RESET: begin
        state_d = ST_LOAD;
      end
      // The cycle after a capture already runs at the new rate and counts
      // toward lock. A request seen here is ignored because the live inputs
      // were just sampled.
      ST_LOAD: begin
        state_d = ST_SETTLE;
        if (run) begin
          step = 1'b1;
          if (terminal) begin
            state_d = ST_LOCKED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // A reload request wins over the settle terminal count
      ST_SETTLE: begin
        if (cfg_update) begin
          state_d = ST_LOAD;
        end else if (run) begin
          step = 1'b1;
          if (terminal) begin
            state_d = ST_LOCKED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (cfg_update) begin
          state_d = ST_LOAD;
        end else begin
          step = run;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    if (state_d == ST_LOAD) begin
      // Capture every channel in the same edge so that phases are aligned
      inc_d = cfg_inc;
      acc_d = cfg_phase;
      cnt_d = '0;
      ack_d = 1'b1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        clk_d[i] = acc_d[i][ACC_W-1];
      end
    end else if (step) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sum      = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
        acc_d[i] = sum[ACC_W-1:0];
        ce_d[i]  = sum[ACC_W];
        clk_d[i] = sum[ACC_W-1];
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State, datapath and output registers
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      acc_q   <= '0;
      inc_q   <= '0;
      cnt_q   <= '0;
      ce_out  <= '0;
      clk_out <= '0;
      cfg_ack <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      cnt_q   <= cnt_d;
      ce_out  <= ce_d;
      clk_out <= clk_d;
      cfg_ack <= ack_d;
      locked  <= locked_d;
    end
  end

endmodule

// File: tb/tb_mf_clken_nco.sv
// Self-checking bench for mf_clken_nco. Expected outputs come from a
// hand-derived table at start-up and from a cycle model afterwards. They are
// queued before each edge and compared after it.
module tb_mf_clken_nco;

  localparam int unsigned NUM_CH      = 5;
  localparam int unsigned ACC_W       = 32;
  localparam int unsigned LOCK_CYCLES = 16;
  localparam int unsigned NVEC        = 20;

  logic                    refclk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH*ACC_W-1:0] cfg_inc;
  logic [NUM_CH*ACC_W-1:0] cfg_phase;
  logic                    cfg_update;
  logic                    cfg_ack;
  logic                    run;
  logic [NUM_CH-1:0]       ce_out;
  logic [NUM_CH-1:0]       clk_out;
  logic                    locked;

  always #5 refclk = ~refclk;

  mf_clken_nco #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .cfg_update(cfg_update),
    .cfg_ack   (cfg_ack),
    .run       (run),
    .ce_out    (ce_out),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  typedef struct packed {
    logic              tbl;
    logic [15:0]       idx;
    logic              ack;
    logic              lck;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] mask;
  } exp_t;

  typedef struct packed {
    logic run;
    logic upd;
    exp_t exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[NVEC];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Behavioural reference: counts the running cycles since the last capture
  bit               m_first;
  bit               m_loadcyc;
  int               m_after;
  logic [ACC_W-1:0] m_acc [NUM_CH];
  logic [ACC_W-1:0] m_inc [NUM_CH];
  exp_t             m_out;

  task automatic model_reset();
    m_first   = 1'b1;
    m_loadcyc = 1'b0;
    m_after   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = '0;
      m_inc[i] = '0;
    end
    m_out = '0;
  endtask

  task automatic model_edge();
    logic [ACC_W:0] s;
    m_out.ack = 1'b0;
    if (m_first || (!m_loadcyc && cfg_update)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_inc[i]     = cfg_inc[i*ACC_W +: ACC_W];
        m_acc[i]     = cfg_phase[i*ACC_W +: ACC_W];
        m_out.clk[i] = m_acc[i][ACC_W-1];
      end
      m_out.ce  = '0;
      m_out.ack = 1'b1;
      m_out.lck = 1'b0;
      m_after   = 0;
      m_loadcyc = 1'b1;
      m_first   = 1'b0;
    end else begin
      m_loadcyc = 1'b0;
      if (run) begin
        for (int i = 0; i < NUM_CH; i++) begin
          s            = {1'b0, m_acc[i]} + {1'b0, m_inc[i]};
          m_out.ce[i]  = s[ACC_W];
          m_acc[i]     = s[ACC_W-1:0];
          m_out.clk[i] = s[ACC_W-1];
        end
        if (m_after < int'(LOCK_CYCLES)) m_after++;
      end else begin
        m_out.ce = '0;
      end
      m_out.lck = (m_after >= int'(LOCK_CYCLES));
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty: got no entry, want one queued expectation");
    end else begin
      e = sb_q.pop_front();
      if ({cfg_ack, locked, ce_out & e.mask, clk_out & e.mask} !==
          {e.ack, e.lck, e.ce & e.mask, e.clk & e.mask}) begin
        n_bad++;
        $display("FAIL %s%0d: got ack=%b locked=%b ce=%b clk=%b, want ack=%b locked=%b ce=%b clk=%b",
                 e.tbl ? "vec" : "cyc", e.idx, cfg_ack, locked, ce_out & e.mask, clk_out & e.mask,
                 e.ack, e.lck, e.ce & e.mask, e.clk & e.mask);
      end
    end
  endtask

  // One clock edge: queue the expectation, let the edge pass, compare
  task automatic tick(input bit use_tbl, input exp_t tv);
    exp_t e;
    model_edge();
    cyc++;
    if (use_tbl) begin
      e = tv;
    end else begin
      e      = m_out;
      e.tbl  = 1'b0;
      e.idx  = 16'(cyc);
      e.mask = '1;
    end
    sb_q.push_back(e);
    @(posedge refclk);
    #1;
    compare_pop();
  endtask

  task automatic step();
    tick(1'b0, '0);
  endtask

  task automatic set_base_cfg();
    cfg_inc   = {32'hFFFF_FFFF, 32'h5555_5555, 32'h0000_0000, 32'h4000_0000, 32'h4000_0000};
    cfg_phase = {32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]        pat_ce  [4];
    logic [2:0]        pat_clk [4];
    logic [NUM_CH-1:0] clk_hold;
    int                n, pulses, pulses4, last, bad_gap, ack_at, lock_at;

    // Start-up table: ch0 4000_0000 phase 0, ch1 same with phase 8000_0000,
    // ch2 idle with phase 8000_0000. Period-4 pattern from the 2nd edge on.
    pat_ce[0]  = 3'b000; pat_clk[0] = 3'b110;
    pat_ce[1]  = 3'b010; pat_clk[1] = 3'b101;
    pat_ce[2]  = 3'b000; pat_clk[2] = 3'b101;
    pat_ce[3]  = 3'b001; pat_clk[3] = 3'b110;
    for (int k = 1; k <= int'(NVEC); k++) begin
      tbl[k-1].run      = 1'b1;
      tbl[k-1].upd      = (k <= 2);
      tbl[k-1].exp.tbl  = 1'b1;
      tbl[k-1].exp.idx  = 16'(k);
      tbl[k-1].exp.ack  = (k == 1);
      tbl[k-1].exp.lck  = (k >= 17);
      tbl[k-1].exp.mask = 5'b00111;
      if (k == 1) begin
        tbl[k-1].exp.ce  = 5'b00000;
        tbl[k-1].exp.clk = 5'b00110;
      end else begin
        tbl[k-1].exp.ce  = {2'b00, pat_ce[(k-2)%4]};
        tbl[k-1].exp.clk = {2'b00, pat_clk[(k-2)%4]};
      end
    end

    // Reset held: toggling inputs must not disturb outputs
    rst_n      = 1'b0;
    run        = 1'b0;
    cfg_update = 1'b0;
    cfg_inc    = '0;
    cfg_phase  = '0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      run        = k[0];
      cfg_update = ~k[0];
      cfg_inc    = {5{$urandom()}};
      cfg_phase  = {5{$urandom()}};
      @(posedge refclk);
      #1;
      chk("reset_hold", {cfg_ack, locked, ce_out, clk_out}, '0);
    end

    set_base_cfg();
    run        = 1'b1;
    cfg_update = 1'b0;
    @(negedge refclk);
    rst_n = 1'b1;

    for (int k = 0; k < int'(NVEC); k++) begin
      run        = tbl[k].run;
      cfg_update = tbl[k].upd;
      tick(1'b1, tbl[k].exp);
    end
    cfg_update = 1'b0;

    // Fractional rate on ch3 and near-full rate on ch4
    pulses  = 0;
    pulses4 = 0;
    last    = -1;
    bad_gap = 0;
    for (int c = 0; c < 30000; c++) begin
      step();
      if (ce_out[4]) pulses4++;
      if (ce_out[3]) begin
        pulses++;
        if (last >= 0 && (c - last) != 2 && (c - last) != 3) bad_gap++;
        last = c;
      end
    end
    chk("frac_count_in_range", 64'(pulses >= 9999 && pulses <= 10001), 64'd1);
    chk("frac_gap", 64'(bad_gap), 64'd0);
    chk("max_inc_pulses", 64'(pulses4 >= 29999), 64'd1);

    // Retune while locked
    cfg_inc[0 +: ACC_W] = 32'h8000_0000;
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    chk("retune_ack_unlock", {cfg_ack, locked}, 2'b10);
    n = 0;
    while (!locked && n < 40) begin
      step();
      n++;
    end
    chk("relock_cycles", 64'(n), 64'(LOCK_CYCLES));
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ce_out[0]) pulses++;
    end
    chk("new_rate_ch0", 64'(pulses), 64'd10);

    // Reload requested exactly at the settle terminal count
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    for (int c = 0; c < int'(LOCK_CYCLES) - 1; c++) step();
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    chk("terminal_retune", {cfg_ack, locked}, 2'b10);
    n = 0;
    while (!locked && n < 40) begin
      step();
      n++;
    end
    chk("relock_after_terminal", 64'(n), 64'(LOCK_CYCLES));

    // Freeze while locked
    clk_hold = clk_out;
    run      = 1'b0;
    pulses   = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      pulses += $countones(ce_out);
    end
    chk("run0_no_ce", 64'(pulses), 64'd0);
    chk("run0_clk_hold", 64'(clk_out), 64'(clk_hold));
    chk("run0_locked_hold", 64'(locked), 64'd1);
    run = 1'b1;
    for (int c = 0; c < 8; c++) step();

    // Freeze during settling lengthens the lock time
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    for (int c = 0; c < 5; c++) step();
    run = 1'b0;
    for (int c = 0; c < 10; c++) step();
    run = 1'b1;
    n = 15;
    while (!locked && n < 60) begin
      step();
      n++;
    end
    chk("lock_extended", 64'(n), 64'(LOCK_CYCLES + 10));

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      run        = ($urandom_range(0, 3) != 0);
      cfg_update = ($urandom_range(0, 19) == 0);
      if (cfg_update) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          cfg_inc[i*ACC_W +: ACC_W]   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
          cfg_phase[i*ACC_W +: ACC_W] = $urandom();
        end
      end
      step();
    end

    // Asynchronous reset mid-run
    set_base_cfg();
    run        = 1'b1;
    cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    for (int c = 0; c < 20; c++) step();
    chk("pre_reset_locked", 64'(locked), 64'd1);
    @(negedge refclk);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {cfg_ack, locked, ce_out, clk_out}, '0);
    model_reset();
    @(posedge refclk);
    #1;
    chk("reset_hold2", {cfg_ack, locked, ce_out, clk_out}, '0);
    @(negedge refclk);
    rst_n   = 1'b1;
    ack_at  = -1;
    lock_at = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (cfg_ack && ack_at < 0) ack_at = k;
      if (locked && lock_at < 0) lock_at = k;
    end
    chk("ack_after_reset", 64'(ack_at), 64'd1);
    chk("lock_after_reset", 64'(lock_at), 64'(1 + LOCK_CYCLES));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
